// File: rtl/bus_arbiter.sv
// Two-master bus arbiter in front of a z80: requests the bus with BUSREQ_L,
// grants one external master at a time once BUSACK_L is seen, and returns the
// bus for a minimum cool-down between external tenures.
// Ports: clk, rst_L (async, active-low); req_L[1:0] master requests (active-low);
//        gnt_L[1:0] master grants (active-low); BUSREQ_L/BUSACK_L z80 handshake;
//        owner = current/last granted master; ext_active = a grant is asserted.
module bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CPU_MIN  = 4
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [1:0] req_L,
  output logic [1:0] gnt_L,
  output logic       BUSREQ_L,
  input  logic       BUSACK_L,
  output logic       owner,
  output logic       ext_active
);

  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int CW = (CPU_MIN  > 0) ? $clog2(CPU_MIN  + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE,
    RETURN,
    COOL
  } state_t;

  state_t          state, state_n;
  logic            owner_n;
  logic            last_owner, last_owner_n;
  logic [HW-1:0]   hold, hold_n;
  logic [CW-1:0]   cool, cool_n;
  logic [1:0]      gnt_n;
  logic            busreq_n;

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    hold_n       = hold;
    cool_n       = cool;

    case (state)
      IDLE: begin
        if (req_L != 2'b11 && cool == '0) begin
          state_n = REQ;
          // Both requesting: round-robin away from the last released master.
          if (req_L == 2'b00) owner_n = ~last_owner;
          else                owner_n = req_L[0];
        end
      end
      REQ: begin
        if (!BUSACK_L) begin
          state_n = GRANT;
          hold_n  = '0;
        end else if (req_L[owner]) begin
          state_n = RETURN;
        end
      end
      GRANT: begin
        if (hold != HW'(HOLD_MAX)) hold_n = hold + 1'b1;
        if (BUSACK_L)
          state_n = RETURN;
        else if (req_L[owner])
          state_n = RELEASE;
        else if (hold == HW'(HOLD_MAX - 1) && !req_L[~owner])
          state_n = RELEASE;
      end
      RELEASE: begin
        last_owner_n = owner;
        state_n      = RETURN;
      end
      RETURN: begin
        if (BUSACK_L) begin
          state_n = COOL;
          cool_n  = CW'(CPU_MIN);
        end
      end
      COOL: begin
        if (cool <= CW'(1)) begin
          cool_n  = '0;
          state_n = IDLE;
        end else begin
          cool_n = cool - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    busreq_n = !(state_n == REQ || state_n == GRANT || state_n == RELEASE);
    gnt_n    = '1;
    if (state_n == GRANT) gnt_n[owner_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      hold       <= '0;
      cool       <= '0;
      gnt_L      <= '1;
      BUSREQ_L   <= 1'b1;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      hold       <= hold_n;
      cool       <= cool_n;
      gnt_L      <= gnt_n;
      BUSREQ_L   <= busreq_n;
    end
  end

  assign ext_active = (gnt_L != 2'b11);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int HOLD = 16;
  localparam int CPU  = 4;

  logic       clk = 1'b0;
  logic       rst_L;
  logic [1:0] req_L;
  logic [1:0] gnt_L;
  logic       BUSREQ_L;
  logic       BUSACK_L;
  logic       owner;
  logic       ext_active;

  bus_arbiter #(.HOLD_MAX(HOLD), .CPU_MIN(CPU)) dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .req_L      (req_L),
    .gnt_L      (gnt_L),
    .BUSREQ_L   (BUSREQ_L),
    .BUSACK_L   (BUSACK_L),
    .owner      (owner),
    .ext_active (ext_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ack_auto;
  logic       brq_snap;
  logic       ack_s;
  logic [1:0] req_s;

  // Reference model: phases of a bus tenure with plain integer bookkeeping.
  typedef enum {M_IDLE, M_ASK, M_OWN, M_TURN, M_GIVEBACK, M_REST} mphase_t;
  mphase_t    m_ph;
  int         m_held, m_cool, m_own, m_last;
  logic [1:0] m_gnt;
  logic       m_brq;

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic       brq;
    logic       own;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_held = 0; m_cool = 0; m_own = 0; m_last = 1;
    m_gnt = 2'b11; m_brq = 1'b1;
  endtask

  task automatic model_step(input logic [1:0] r, input logic a);
    case (m_ph)
      M_IDLE:
        if (r != 2'b11 && m_cool == 0) begin
          if (r == 2'b00) m_own = 1 - m_last;
          else            m_own = (r == 2'b10) ? 0 : 1;
          m_ph = M_ASK;
        end
      M_ASK:
        if (!a) begin m_ph = M_OWN; m_held = 0; end
        else if (r[m_own]) m_ph = M_GIVEBACK;
      M_OWN:
        if (a) m_ph = M_GIVEBACK;
        else if (r[m_own]) m_ph = M_TURN;
        else if (m_held == HOLD - 1 && !r[1 - m_own]) m_ph = M_TURN;
        else m_held = (m_held < HOLD) ? m_held + 1 : HOLD;
      M_TURN: begin m_last = m_own; m_ph = M_GIVEBACK; end
      M_GIVEBACK:
        if (a) begin m_cool = CPU; m_ph = M_REST; end
      M_REST: begin
        m_cool = m_cool - 1;
        if (m_cool <= 0) begin m_cool = 0; m_ph = M_IDLE; end
      end
      default: m_ph = M_IDLE;
    endcase
    m_brq = !(m_ph == M_ASK || m_ph == M_OWN || m_ph == M_TURN);
    m_gnt = (m_ph == M_OWN) ? ((m_own == 1) ? 2'b01 : 2'b10) : 2'b11;
  endtask

  // One clock: sample inputs at the edge, step the model, emulate a z80 that
  // mirrors BUSREQ_L one cycle late, and check the bus invariants.
  task automatic tick();
    req_s    = req_L;
    ack_s    = BUSACK_L;
    brq_snap = BUSREQ_L;
    @(posedge clk);
    #1;
    if (rst_L) model_step(req_s, ack_s);
    if (ack_auto) BUSACK_L = brq_snap;
    check("gnt_exclusive", {7'd0, gnt_L == 2'b00}, 8'd0);
    check("gnt_needs_bus", {7'd0, (gnt_L != 2'b11) && (BUSREQ_L || ack_s)}, 8'd0);
  endtask

  task automatic do_reset();
    rst_L    = 1'b0;
    BUSACK_L = 1'b1;
    ack_auto = 1'b1;
    tick();
    tick();
    rst_L = 1'b1;
    model_reset();
  endtask

  task automatic wait_gnt(input int bound, output int n);
    n = 0;
    while (gnt_L == 2'b11 && n < bound) begin
      tick();
      n++;
    end
    check("wait_grant_bound", {7'd0, n < bound}, 8'd1);
  endtask

  task automatic run_len(input logic [1:0] g, input int bound, output int n);
    n = 0;
    while (gnt_L == g && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic mid_cycle_reset();
    #2 rst_L = 1'b0;
    #1;
    check("async_rst_gnt", {6'd0, gnt_L}, 8'h03);
    check("async_rst_brq", {7'd0, BUSREQ_L}, 8'd1);
    check("async_rst_ext", {7'd0, ext_active}, 8'd0);
    check("async_rst_owner", {7'd0, owner}, 8'd0);
    #1 rst_L = 1'b1;
    BUSACK_L = 1'b1;
    #1;
    check("no_req_before_edge", {7'd0, BUSREQ_L}, 8'd1);
    model_reset();
  endtask

  initial begin
    int n;
    rst_L    = 1'b1;
    req_L    = 2'b11;
    BUSACK_L = 1'b1;
    ack_auto = 1'b1;
    model_reset();

    #1 rst_L = 1'b0;
    #1;
    check("reset_gnt", {6'd0, gnt_L}, 8'h03);
    check("reset_brq", {7'd0, BUSREQ_L}, 8'd1);
    check("reset_owner", {7'd0, owner}, 8'd0);
    check("reset_ext", {7'd0, ext_active}, 8'd0);
    tick();
    tick();
    rst_L = 1'b1;
    model_reset();

    // Single-master tenure for each master, cycle by cycle.
    tbl[0]  = '{2'b10, 2'b11, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 2'b11, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 2'b10, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 2'b10, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b11, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 2'b11, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 2'b11, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, 2'b11, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 2'b11, 1'b1, 1'b0};
    tbl[9]  = '{2'b01, 2'b11, 1'b1, 1'b0};
    tbl[10] = '{2'b01, 2'b11, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 2'b11, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 2'b11, 1'b0, 1'b1};
    tbl[13] = '{2'b01, 2'b11, 1'b0, 1'b1};
    tbl[14] = '{2'b01, 2'b01, 1'b0, 1'b1};
    tbl[15] = '{2'b11, 2'b11, 1'b0, 1'b1};
    tbl[16] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[17] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[18] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[19] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[20] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[21] = '{2'b11, 2'b11, 1'b1, 1'b1};
    tbl[22] = '{2'b11, 2'b11, 1'b1, 1'b1};
    for (int i = 0; i < 23; i++) begin
      req_L = tbl[i].req;
      tick();
      check($sformatf("vec%0d", i), {3'd0, gnt_L, BUSREQ_L, owner, ext_active},
            {3'd0, tbl[i].gnt, tbl[i].brq, tbl[i].own, tbl[i].gnt != 2'b11});
    end

    // Both masters requesting: hold limit, turnaround + cool-down gap, alternation.
    req_L = 2'b11;
    do_reset();
    req_L = 2'b00;
    wait_gnt(20, n);
    check("rr_first_gnt", {6'd0, gnt_L}, 8'h02);
    run_len(2'b10, 100, n);
    check("rr_hold0_len", n[7:0], 8'd16);
    run_len(2'b11, 50, n);
    check("rr_gap0_len", n[7:0], 8'd10);
    check("rr_second_gnt", {6'd0, gnt_L}, 8'h01);
    run_len(2'b01, 100, n);
    check("rr_hold1_len", n[7:0], 8'd16);
    run_len(2'b11, 50, n);
    check("rr_third_gnt", {6'd0, gnt_L}, 8'h02);

    // Reset mid master-1 grant: drops immediately, then master 0 is favoured.
    run_len(2'b10, 100, n);
    wait_gnt(20, n);
    check("pre_rst_gnt", {6'd0, gnt_L}, 8'h01);
    tick();
    tick();
    mid_cycle_reset();
    wait_gnt(20, n);
    check("post_rst_gnt", {6'd0, gnt_L}, 8'h02);

    // Request withdrawn before the z80 acknowledges.
    req_L = 2'b11;
    do_reset();
    ack_auto = 1'b0;
    req_L = 2'b01;
    tick();
    check("wd_req", {6'd0, BUSREQ_L, owner}, 8'h01);
    req_L = 2'b11;
    tick();
    check("wd_return_brq", {7'd0, BUSREQ_L}, 8'd1);
    tick();
    req_L = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wd_cool_ignores_req", {6'd0, gnt_L, BUSREQ_L}, 8'h07);
    end
    tick();
    check("wd_next_req", {6'd0, BUSREQ_L, owner}, 8'h00);

    // z80 drops its acknowledge while a grant is active.
    ack_auto = 1'b1;
    wait_gnt(20, n);
    check("viol_gnt", {6'd0, gnt_L}, 8'h02);
    tick();
    ack_auto = 1'b0;
    BUSACK_L = 1'b1;
    tick();
    check("viol_drop", {5'd0, gnt_L, ext_active}, 8'h06);
    check("viol_brq", {7'd0, BUSREQ_L}, 8'd1);
    req_L = 2'b11;
    tick();
    ack_auto = 1'b1;

    // Randomized traffic against the reference model.
    req_L = 2'b11;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) ack_auto = ~ack_auto;
      if (!ack_auto) BUSACK_L = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) req_L[0] = ~req_L[0];
      if ($urandom_range(0, 11) == 0) req_L[1] = ~req_L[1];
      tick();
      check("model", {4'd0, gnt_L, BUSREQ_L, owner, ext_active},
            {3'd0, 1'b0, m_gnt, m_brq, m_own[0], m_gnt != 2'b11});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, max cycles an external master may hold the bus while the other master is waiting.
REQ-002 Parameter CPU_MIN, default 4, min cycles the z80 owns the bus between two external tenures.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst_L  input  1  asynchronous, active-low reset.
REQ-005 req_L  input  2  per-master bus requests (masters 0 and 1), active-low, level-held for the whole tenure.
REQ-006 gnt_L  output  2  per-master grants, active-low, at most one low at any time.
REQ-007 BUSREQ_L  output  1  bus request to the z80, active-low.
REQ-008 BUSACK_L  input  1  bus acknowledge from the z80, active-low.
REQ-009 owner  output  1  index of the granted or last-granted master.
REQ-010 ext_active  output  1  high while any gnt_L bit is low.

Function
REQ-011 States SHALL be IDLE, REQ, GRANT, RELEASE, RETURN, COOL.
REQ-012 IDLE: BUSREQ_L=1, gnt_L=2'b11; if any req_L bit is low and the cool-down counter is 0 -> REQ with the chosen master latched into owner.
REQ-013 Selection: only one requesting -> that master; both requesting -> the master that is not last_owner (round-robin).
REQ-014 REQ: BUSREQ_L=0; BUSACK_L sampled low -> GRANT; req_L[owner] withdrawn before ack -> RETURN.
REQ-015 GRANT: gnt_L[owner]=0, BUSREQ_L=0, hold counter increments each cycle and saturates at HOLD_MAX.
REQ-016 GRANT exit: req_L[owner] high -> RELEASE; or hold counter == HOLD_MAX-1 and req_L[~owner] low -> RELEASE (preemption).
REQ-017 GRANT with only the owner requesting SHALL hold the bus indefinitely; no preemption.
REQ-018 RELEASE: gnt_L=2'b11, BUSREQ_L held 0 for exactly one cycle (bus turnaround), last_owner<=owner -> RETURN.
REQ-019 RETURN: BUSREQ_L=1; wait until BUSACK_L sampled high -> COOL, loading cool-down counter with CPU_MIN.
REQ-020 COOL: counter decrements each cycle; at 0 -> IDLE; requests are ignored in COOL.
REQ-021 Grant latency from req_L falling in IDLE with z80 acking in one cycle: gnt_L low exactly 3 clk edges later.
REQ-022 BUSACK_L rising while in GRANT (protocol violation) SHALL deassert gnt_L the same cycle and go to RETURN.
REQ-023 Hold counter SHALL clear on every entry to GRANT; cool-down counter width ceil(log2(CPU_MIN+1)).
REQ-024 gnt_L and BUSREQ_L SHALL be registered outputs; no combinational path from req_L or BUSACK_L.

Reset
REQ-025 rst_L low SHALL immediately force gnt_L=2'b11, BUSREQ_L=1, owner=0, ext_active=0, state=IDLE, counters=0, last_owner=1, irrespective of clk.
REQ-026 Reset during GRANT SHALL drop the grant asynchronously; after release, first arbitration SHALL favour master 0.
REQ-027 After rst_L rises, no request SHALL be issued until the first posedge with rst_L high.

Verification
REQ-028 req_L=2'b10, BUSACK_L follows BUSREQ_L after 1 cycle -> gnt_L=2'b10 on 3rd edge, owner=0; release req -> BUSREQ_L=1 two edges later.
REQ-029 req_L=2'b00 held continuously, HOLD_MAX=16 -> master 0 granted 16 cycles, 1-cycle turnaround, RETURN, 4 COOL cycles, then master 1 granted; alternation repeats.
REQ-030 req_L=2'b11->2'b01 in REQ then withdrawn before BUSACK_L falls -> no gnt_L low ever, BUSREQ_L returns to 1, state reaches COOL.
REQ-031 rst_L pulsed low mid-GRANT between clk edges -> gnt_L=2'b11 and BUSREQ_L=1 before the next edge.
REQ-032 BUSACK_L forced high during GRANT -> gnt_L=2'b11 on next edge, ext_active=0.
REQ-033 Assertion throughout all runs: gnt_L never 2'b00; gnt_L low only while BUSACK_L low and BUSREQ_L low.
